spi_bus_arbiter: RTL and testbench

- Shares one physical SPI bus (SCK/COPI/CIPO) between NumReq SPI host requesters, e.g. the flash host and the LCD host.
- Each requester owns one device chip select on the shared bus.
- Grants the bus round-robin, one transaction at a time, and enforces a guard gap with all chip selects high between owners.
- Sits between the system's SPI host blocks and the board-level SPI pins, or the SPI DPI models in simulation.

---
 rtl/spi_bus_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spi_bus_arbiter
//
// Shares one physical SPI bus (SCK/COPI/CIPO) between NumReq SPI host
// requesters. Each requester owns one device chip select. The bus is granted
// round-robin, one transaction at a time, and a guard gap with every chip
// select high separates consecutive owners.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN
//   Defined     : a grant is forcibly released after TimeoutCycles cycles of
//                 another request waiting, and timeout_o pulses for one cycle.
//   Not defined : no timeout counter, timeout_o stays 0, a grant lasts until
//                 done or abandon.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   req_i        per-requester bus request (level, held until done)
//   done_i       per-requester end-of-transaction pulse
//   gnt_o        one-hot registered grant
//   req_sck_i    per-requester SCK
//   req_copi_i   per-requester COPI
//   req_cs_ni    per-requester active-low chip select
//   req_cipo_o   CIPO returned to each requester (only the owner sees data)
//   spi_sck_o    shared bus SCK
//   spi_copi_o   shared bus COPI
//   spi_cipo_i   shared bus CIPO
//   spi_cs_no    device chip selects, active low
//   busy_o       high while a grant or guard gap is in progress
//   owner_o      index of the current or last owner
//   timeout_o    one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module spi_bus_arbiter #(
  parameter int NumReq        = 2,
  parameter int CsIdleCycles  = 4,
  parameter int TimeoutCycles = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumReq-1:0]         req_i,
  input  logic [NumReq-1:0]         done_i,
  output logic [NumReq-1:0]         gnt_o,
  input  logic [NumReq-1:0]         req_sck_i,
  input  logic [NumReq-1:0]         req_copi_i,
  input  logic [NumReq-1:0]         req_cs_ni,
  output logic [NumReq-1:0]         req_cipo_o,
  output logic                      spi_sck_o,
  output logic                      spi_copi_o,
  input  logic                      spi_cipo_i,
  output logic [NumReq-1:0]         spi_cs_no,
  output logic                      busy_o,
  output logic [$clog2(NumReq)-1:0] owner_o,
  output logic                      timeout_o
);

  localparam int OwnW   = $clog2(NumReq);
  localparam int GuardW = (CsIdleCycles > 1) ? $clog2(CsIdleCycles) : 1;

  // Guard counter reload: counting down to zero inclusive gives exactly
  // CsIdleCycles cycles in the guard state.
  localparam logic [GuardW-1:0] GuardLoad =
    (CsIdleCycles > 0) ? GuardW'(CsIdleCycles - 1) : {GuardW{1'b0}};

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StGuard = 2'd2;

  logic [1:0]        state_r, state_s;
  logic [NumReq-1:0] gnt_r, gnt_s;
  logic [OwnW-1:0]   owner_r, owner_s;
  logic [OwnW-1:0]   ptr_r, ptr_s;
  logic [GuardW-1:0] guard_r, guard_s;
  logic              timeout_r, timeout_s;
  logic              busy_r;

  logic              pick_valid_s;
  logic [OwnW-1:0]   pick_idx_s;
  logic [OwnW:0]     cand_s;
  logic              release_s;
  logic              to_hit_s;

  // Owner finished or abandoned; both in one cycle is still one release.
  assign release_s = done_i[owner_r] | ~req_i[owner_r];

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int ToW = $clog2(TimeoutCycles + 1);

  logic [ToW-1:0] to_cnt_r;
  logic           others_s;

  // Another requester is waiting while the current owner holds the bus.
  assign others_s = |(req_i & ~gnt_r);
  assign to_hit_s = (state_r == StGrant) && (to_cnt_r == ToW'(TimeoutCycles));

  // Grant-length counter: zero outside GRANT so every grant starts from 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_r <= {ToW{1'b0}};
    end else if (state_r != StGrant) begin
      to_cnt_r <= {ToW{1'b0}};
    end else if (others_s && !to_hit_s) begin
      to_cnt_r <= to_cnt_r + ToW'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end
`else
  logic unused_timeout_cfg_s;

  assign to_hit_s             = 1'b0;
  assign unused_timeout_cfg_s = (TimeoutCycles > 0);
`endif

  // Round-robin search: first set request upward from pointer+1, wrapping.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = ptr_r;
    cand_s       = {(OwnW+1){1'b0}};
    for (int k = 1; k <= NumReq; k++) begin
      cand_s = {1'b0, ptr_r} + (OwnW+1)'(k);
      if (cand_s >= (OwnW+1)'(NumReq)) begin
        cand_s = cand_s - (OwnW+1)'(NumReq);
      end else begin
        cand_s = cand_s;
      end
      if (!pick_valid_s && req_i[cand_s[OwnW-1:0]]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = cand_s[OwnW-1:0];
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Next-state logic for the IDLE / GRANT / GUARD controller.
  always_comb begin
    state_s   = state_r;
    gnt_s     = gnt_r;
    owner_s   = owner_r;
    ptr_s     = ptr_r;
    guard_s   = guard_r;
    timeout_s = 1'b0;
    case (state_r)
      StIdle: begin
        if (pick_valid_s) begin
          gnt_s   = {{(NumReq-1){1'b0}}, 1'b1} << pick_idx_s;
          owner_s = pick_idx_s;
          ptr_s   = pick_idx_s;
          state_s = StGrant;
        end else begin
          state_s = StIdle;
        end
      end
      StGrant: begin
        if (release_s || to_hit_s) begin
          gnt_s     = {NumReq{1'b0}};
          // A regular release in the same cycle takes precedence.
          timeout_s = to_hit_s & ~release_s;
          if (CsIdleCycles > 0) begin
            state_s = StGuard;
            guard_s = GuardLoad;
          end else begin
            state_s = StIdle;
          end
        end else begin
          state_s = StGrant;
        end
      end
      StGuard: begin
        gnt_s = {NumReq{1'b0}};
        if (guard_r == {GuardW{1'b0}}) begin
          state_s = StIdle;
        end else begin
          guard_s = guard_r - GuardW'(1);
        end
      end
      default: begin
        state_s = StIdle;
        gnt_s   = {NumReq{1'b0}};
      end
    endcase
  end

  // Controller state and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= StIdle;
      gnt_r     <= {NumReq{1'b0}};
      owner_r   <= {OwnW{1'b0}};
      ptr_r     <= OwnW'(NumReq - 1);
      guard_r   <= {GuardW{1'b0}};
      timeout_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      owner_r   <= owner_s;
      ptr_r     <= ptr_s;
      guard_r   <= guard_s;
      timeout_r <= timeout_s;
      busy_r    <= (state_s != StIdle);
    end
  end

  // Bus mux driven from the registered one-hot grant, so reset deasserts
  // every chip select immediately and nothing leaks outside GRANT.
  always_comb begin
    spi_sck_o  = |(gnt_r & req_sck_i);
    spi_copi_o = |(gnt_r & req_copi_i);
    spi_cs_no  = {NumReq{1'b1}};
    req_cipo_o = {NumReq{1'b0}};
    for (int i = 0; i < NumReq; i++) begin
      if (gnt_r[i]) begin
        spi_cs_no[i]  = req_cs_ni[i];
        req_cipo_o[i] = spi_cipo_i;
      end else begin
        spi_cs_no[i]  = 1'b1;
        req_cipo_o[i] = 1'b0;
      end
    end
  end

  assign gnt_o     = gnt_r;
  assign owner_o   = owner_r;
  assign busy_o    = busy_r;
  assign timeout_o = timeout_r;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_bus_arbiter
//
// Directed bench for spi_bus_arbiter with NumReq=2, CsIdleCycles=4,
// TimeoutCycles=16. Expected grant/owner/busy/timeout values are queued when
// stimulus is applied and compared after the following clock edge.
// -----------------------------------------------------------------------------
module tb_spi_bus_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [1:0] req_i, done_i, gnt_o;
  logic [1:0] req_sck_i, req_copi_i, req_cs_ni, req_cipo_o;
  logic       spi_sck_o, spi_copi_o, spi_cipo_i;
  logic [1:0] spi_cs_no;
  logic       busy_o;
  logic [0:0] owner_o;
  logic       timeout_o;

  always #5 clk_i = ~clk_i;

  spi_bus_arbiter #(
    .NumReq(2),
    .CsIdleCycles(4),
    .TimeoutCycles(16)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req_i(req_i),
    .done_i(done_i),
    .gnt_o(gnt_o),
    .req_sck_i(req_sck_i),
    .req_copi_i(req_copi_i),
    .req_cs_ni(req_cs_ni),
    .req_cipo_o(req_cipo_o),
    .spi_sck_o(spi_sck_o),
    .spi_copi_o(spi_copi_o),
    .spi_cipo_i(spi_cipo_i),
    .spi_cs_no(spi_cs_no),
    .busy_o(busy_o),
    .owner_o(owner_o),
    .timeout_o(timeout_o)
  );

  typedef struct {
    string      tag;
    logic [1:0] gnt;
    logic       owner;
    logic       busy;
    logic       tmo;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive non-idle values on every bus input so idle outputs are meaningful.
  task automatic busy_inputs();
    req_cs_ni  = 2'b00;
    req_sck_i  = 2'b11;
    req_copi_i = 2'b11;
    spi_cipo_i = 1'b1;
  endtask

  // Queue the expectation for the next edge, advance, then pop and compare.
  task automatic step(input string tag, input logic [1:0] g, input logic o,
                      input logic b, input logic t);
    exp_t e;
    e.tag = tag; e.gnt = g; e.owner = o; e.busy = b; e.tmo = t;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    e = sb_q.pop_front();
    chk({e.tag, ".gnt"},   8'(gnt_o),     8'(e.gnt));
    chk({e.tag, ".owner"}, 8'(owner_o),   8'(e.owner));
    chk({e.tag, ".busy"},  8'(busy_o),    8'(e.busy));
    chk({e.tag, ".tmo"},   8'(timeout_o), 8'(e.tmo));
    if (e.gnt == 2'b00) begin
      chk({e.tag, ".cs_idle"},  8'(spi_cs_no),  8'(2'b11));
      chk({e.tag, ".sck_idle"}, 8'(spi_sck_o),  8'(1'b0));
      chk({e.tag, ".copi_idle"},8'(spi_copi_o), 8'(1'b0));
      chk({e.tag, ".cipo_idle"},8'(req_cipo_o), 8'(2'b00));
    end else begin
      e.tag = e.tag;
    end
  endtask

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0;
    req_i  = 2'b00;
    done_i = 2'b00;
    busy_inputs();
    #12;
    // Reset values with busy bus inputs applied.
    chk("rst.gnt",   8'(gnt_o),      8'(2'b00));
    chk("rst.busy",  8'(busy_o),     8'(1'b0));
    chk("rst.owner", 8'(owner_o),    8'(1'b0));
    chk("rst.tmo",   8'(timeout_o),  8'(1'b0));
    chk("rst.cs",    8'(spi_cs_no),  8'(2'b11));
    chk("rst.sck",   8'(spi_sck_o),  8'(1'b0));
    chk("rst.copi",  8'(spi_copi_o), 8'(1'b0));
    chk("rst.cipo",  8'(req_cipo_o), 8'(2'b00));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Simultaneous requests after reset: requester 0 wins.
    req_cs_ni = 2'b11; req_sck_i = 2'b00; req_copi_i = 2'b00; spi_cipo_i = 1'b0;
    req_i = 2'b11;
    step("arb0", 2'b01, 1'b0, 1'b1, 1'b0);
    req_cs_ni = 2'b10; #1;
    chk("cs_follow0", 8'(spi_cs_no), 8'(2'b10));
    req_cs_ni = 2'b01; #1;
    chk("cs_follow1", 8'(spi_cs_no), 8'(2'b11));

    // Owner 0 done with requester 1 pending: guard gap then grant 1.
    busy_inputs();
    done_i = 2'b01;
    step("rel0", 2'b00, 1'b0, 1'b1, 1'b0);
    done_i = 2'b00;
    for (int i = 0; i < 3; i++) step("guard0", 2'b00, 1'b0, 1'b1, 1'b0);
    step("idle0", 2'b00, 1'b0, 1'b0, 1'b0);
    step("arb1", 2'b10, 1'b1, 1'b1, 1'b0);

    // Bus mux follows owner 1 with no latency; requester 0 is invisible.
    spi_cipo_i = 1'b1; #1;
    chk("cipo_owner1", 8'(req_cipo_o), 8'(2'b10));
    for (int i = 0; i < 4; i++) begin
      logic [1:0] pat;
      pat        = 2'(i);
      req_sck_i  = {pat[0], ~pat[0]};
      req_copi_i = {pat[1], ~pat[1]};
      req_cs_ni  = {pat[1], 1'b0};
      #1;
      chk("mux_sck",  8'(spi_sck_o),  8'(pat[0]));
      chk("mux_copi", 8'(spi_copi_o), 8'(pat[1]));
      chk("mux_cs",   8'(spi_cs_no),  8'({pat[1], 1'b1}));
    end
    spi_cipo_i = 1'b0; #1;
    chk("cipo_zero", 8'(req_cipo_o), 8'(2'b00));

    // Owner 1 done and drops its request together: one release.
    busy_inputs();
    done_i = 2'b10; req_i = 2'b01;
    step("rel1", 2'b00, 1'b1, 1'b1, 1'b0);
    done_i = 2'b00;
    for (int i = 0; i < 3; i++) step("guard1", 2'b00, 1'b1, 1'b1, 1'b0);
    step("idle1", 2'b00, 1'b1, 1'b0, 1'b0);
    step("arb0b", 2'b01, 1'b0, 1'b1, 1'b0);

    // Non-owner done is ignored; owner abandons by dropping its request.
    done_i = 2'b10;
    step("ignore", 2'b01, 1'b0, 1'b1, 1'b0);
    done_i = 2'b00;
    busy_inputs();
    req_i = 2'b00;
    step("abandon", 2'b00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("guard2", 2'b00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("idle2", 2'b00, 1'b0, 1'b0, 1'b0);

    // Single requester is re-granted after every guard period.
    req_i = 2'b01;
    step("solo", 2'b01, 1'b0, 1'b1, 1'b0);
    busy_inputs();
    done_i = 2'b01;
    step("solo_rel", 2'b00, 1'b0, 1'b1, 1'b0);
    done_i = 2'b00;
    for (int i = 0; i < 3; i++) step("guard3", 2'b00, 1'b0, 1'b1, 1'b0);
    step("idle3", 2'b00, 1'b0, 1'b0, 1'b0);
    step("solo_again", 2'b01, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-grant: CS released before any clock edge.
    req_cs_ni = 2'b00; #3;
    chk("pre_rst_cs", 8'(spi_cs_no), 8'(2'b10));
    rst_ni = 1'b0; #1;
    chk("async_rst.cs",   8'(spi_cs_no), 8'(2'b11));
    chk("async_rst.gnt",  8'(gnt_o),     8'(2'b00));
    chk("async_rst.busy", 8'(busy_o),    8'(1'b0));
    req_i = 2'b00;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    // Pointer was reset, so requester 0 wins again.
    req_i = 2'b11;
    step("post_rst", 2'b01, 1'b0, 1'b1, 1'b0);

    // Owner 0 holds the bus with requester 1 waiting and never finishes.
`ifdef SPI_ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) step("to_hold", 2'b01, 1'b0, 1'b1, 1'b0);
    busy_inputs();
    step("to_fire", 2'b00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("to_guard", 2'b00, 1'b0, 1'b1, 1'b0);
    step("to_idle", 2'b00, 1'b0, 1'b0, 1'b0);
    step("to_next", 2'b10, 1'b1, 1'b1, 1'b0);
`else
    for (int i = 0; i < 30; i++) step("no_to", 2'b01, 1'b0, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
